// File: rtl/exu_dp_arb.sv
// Execution-unit datapath arbiter: steers one instruction-class controller onto the shared
// GPR/ALU datapath, with ownership lock for multi-cycle classes and a registered writeback.
module exu_dp_arb #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned GPR_AW    = 5,
    parameter int unsigned ALU_OPC_W = 4,
    parameter int unsigned TMO_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iexec_req_vld,
    output logic                           iexec_req_rdy,
    input  logic [NUM_SRC-1:0]             sel,
    input  logic [NUM_SRC-1:0]             src_multi,
    input  logic [NUM_SRC-1:0]             src_done,
    input  logic [NUM_SRC*GPR_AW-1:0]      src_gpr_raddr1,
    input  logic [NUM_SRC-1:0]             src_gpr_wen,
    input  logic [NUM_SRC*GPR_AW-1:0]      src_gpr_waddr,
    input  logic [NUM_SRC*XLEN-1:0]        src_gpr_wdata,
    input  logic [NUM_SRC*ALU_OPC_W-1:0]   src_alu_opcode,
    input  logic [NUM_SRC*XLEN-1:0]        src_alu_src1,
    input  logic [NUM_SRC*XLEN-1:0]        src_alu_src2,
    output logic [GPR_AW-1:0]              gpr_raddr1,
    output logic [ALU_OPC_W-1:0]           alu_opcode,
    output logic [XLEN-1:0]                alu_src1,
    output logic [XLEN-1:0]                alu_src2,
    output logic                           gpr_wen,
    output logic [GPR_AW-1:0]              gpr_waddr,
    output logic [XLEN-1:0]                gpr_wdata,
    output logic                           busy,
    output logic                           sel_err,
    output logic                           tmo_err
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e               state_q;
    logic [NUM_SRC-1:0]   own_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic                 sel_err_q;
    logic                 tmo_err_q;
    logic                 gpr_wen_q;
    logic [GPR_AW-1:0]    gpr_waddr_q;
    logic [XLEN-1:0]      gpr_wdata_q;

    logic [NUM_SRC-1:0]   act;
    logic                 accept;
    logic                 sel_ok;
    logic                 multi;
    logic                 sel_done;
    logic                 own_done;
    logic                 wen_any;
    logic                 wen_nx;
    logic [GPR_AW-1:0]    waddr_mux;
    logic [XLEN-1:0]      wdata_mux;

    assign iexec_req_rdy = (state_q == StIdle) & ~rst;
    assign accept        = iexec_req_vld & iexec_req_rdy;
    assign act           = (state_q == StIdle) ? sel : own_q;
    assign sel_ok        = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign multi         = |(sel & src_multi);
    assign sel_done      = |(sel & src_done);
    assign own_done      = |(own_q & src_done);

    // AND-OR mux: a zero select yields all-zero outputs, never X or a stale source.
    always_comb begin
        gpr_raddr1 = '0;
        alu_opcode = '0;
        alu_src1   = '0;
        alu_src2   = '0;
        waddr_mux  = '0;
        wdata_mux  = '0;
        wen_any    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (act[i]) begin
                gpr_raddr1 = gpr_raddr1 | src_gpr_raddr1[i*GPR_AW +: GPR_AW];
                alu_opcode = alu_opcode | src_alu_opcode[i*ALU_OPC_W +: ALU_OPC_W];
                alu_src1   = alu_src1 | src_alu_src1[i*XLEN +: XLEN];
                alu_src2   = alu_src2 | src_alu_src2[i*XLEN +: XLEN];
                waddr_mux  = waddr_mux | src_gpr_waddr[i*GPR_AW +: GPR_AW];
                wdata_mux  = wdata_mux | src_gpr_wdata[i*XLEN +: XLEN];
                wen_any    = wen_any | src_gpr_wen[i];
            end
        end
    end

    // x0 is hard-wired zero, so writes to it never reach the GPR file.
    assign wen_nx = wen_any & (waddr_mux != '0) &
                    ((accept & sel_ok) | (state_q == StLock));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            own_q       <= '0;
            tmo_cnt_q   <= '0;
            sel_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else begin
            gpr_wen_q <= wen_nx;
            if (wen_nx) begin
                gpr_waddr_q <= waddr_mux;
                gpr_wdata_q <= wdata_mux;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!sel_ok) begin
                            sel_err_q <= 1'b1;
                        end else begin
                            own_q <= sel;
                            // Same-cycle completion never enters LOCK.
                            if (multi && !sel_done) begin
                                state_q   <= StLock;
                                tmo_cnt_q <= '0;
                            end
                        end
                    end
                end
                StLock: begin
                    if (own_done) begin
                        state_q <= StIdle;
                    end else if (tmo_cnt_q == {TMO_W{1'b1}}) begin
                        state_q   <= StIdle;
                        tmo_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q == StLock);
    assign sel_err   = sel_err_q;
    assign tmo_err   = tmo_err_q;
    assign gpr_wen   = gpr_wen_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_exu_dp_arb.sv
// Scoreboard bench for exu_dp_arb: directed scenarios then random traffic, checked against a
// cycle-level behavioural model; writebacks are queued and compared by a separate monitor.
module tb_exu_dp_arb;
    localparam int N  = 4;
    localparam int XL = 32;
    localparam int AW = 5;
    localparam int OW = 4;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            vld;
    logic            rdy;
    logic [N-1:0]    sel, multi, done, wen;
    logic [N*AW-1:0] raddr, waddr;
    logic [N*XL-1:0] wdata, s1, s2;
    logic [N*OW-1:0] opc;
    logic [AW-1:0]   o_raddr, o_waddr;
    logic [OW-1:0]   o_opc;
    logic [XL-1:0]   o_s1, o_s2, o_wdata;
    logic            o_wen, o_busy, o_serr, o_terr;

    exu_dp_arb #(
        .NUM_SRC(N), .XLEN(XL), .GPR_AW(AW), .ALU_OPC_W(OW), .TMO_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .iexec_req_vld(vld), .iexec_req_rdy(rdy),
        .sel(sel), .src_multi(multi), .src_done(done),
        .src_gpr_raddr1(raddr), .src_gpr_wen(wen), .src_gpr_waddr(waddr),
        .src_gpr_wdata(wdata), .src_alu_opcode(opc), .src_alu_src1(s1), .src_alu_src2(s2),
        .gpr_raddr1(o_raddr), .alu_opcode(o_opc), .alu_src1(o_s1), .alu_src2(o_s2),
        .gpr_wen(o_wen), .gpr_waddr(o_waddr), .gpr_wdata(o_wdata),
        .busy(o_busy), .sel_err(o_serr), .tmo_err(o_terr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [XL-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state: who owns the datapath and for how long.
    bit m_lock = 0;
    int m_own  = 0;
    int m_cnt  = 0;
    bit m_serr = 0;
    bit m_terr = 0;

    always @(negedge clk) begin
        logic [N-1:0]  a;
        logic [AW-1:0] e_ra;
        logic [OW-1:0] e_op;
        logic [XL-1:0] e_s1, e_s2;
        int            src;
        if (m_lock) begin
            a = '0;
            a[m_own] = 1'b1;
        end else begin
            a = sel;
        end
        e_ra = '0; e_op = '0; e_s1 = '0; e_s2 = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                e_ra |= raddr[i*AW +: AW];
                e_op |= opc[i*OW +: OW];
                e_s1 |= s1[i*XL +: XL];
                e_s2 |= s2[i*XL +: XL];
            end
        end
        chk("rdy", 64'(rdy), 64'(!m_lock && !rst));
        chk("busy", 64'(o_busy), 64'(m_lock));
        chk("sel_err", 64'(o_serr), 64'(m_serr));
        chk("tmo_err", 64'(o_terr), 64'(m_terr));
        chk("gpr_raddr1", 64'(o_raddr), 64'(e_ra));
        chk("alu_opcode", 64'(o_opc), 64'(e_op));
        chk("alu_src1", 64'(o_s1), 64'(e_s1));
        chk("alu_src2", 64'(o_s2), 64'(e_s2));

        src = -1;
        if (rst) begin
            m_lock = 0; m_cnt = 0; m_serr = 0; m_terr = 0;
        end else if (!m_lock) begin
            if (vld) begin
                if ($onehot(sel)) begin
                    for (int i = 0; i < N; i++) if (sel[i]) src = i;
                    if (multi[src] && !done[src]) begin
                        m_lock = 1; m_own = src; m_cnt = 0;
                    end
                end else begin
                    m_serr = 1;
                end
            end
        end else begin
            src = m_own;
            if (done[m_own]) begin
                m_lock = 0;
            end else if (m_cnt == (1 << TW) - 1) begin
                m_lock = 0; m_terr = 1;
            end else begin
                m_cnt++;
            end
        end
        if (src >= 0 && wen[src] && waddr[src*AW +: AW] != 0)
            exp_q.push_back('{a: waddr[src*AW +: AW], d: wdata[src*XL +: XL]});
    end

    // Writeback monitor: registered outputs examined just after each edge.
    logic [AW-1:0] last_a = '0;
    logic [XL-1:0] last_d = '0;
    always @(posedge clk) begin
        logic r;
        wr_t  e;
        r = rst;
        #2;
        if (r) begin
            last_a = '0;
            last_d = '0;
        end
        chk("gpr_wen", 64'(o_wen), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_a = e.a;
            last_d = e.d;
        end
        chk("gpr_waddr", 64'(o_waddr), 64'(last_a));
        chk("gpr_wdata", 64'(o_wdata), 64'(last_d));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            raddr[i*AW +: AW] = AW'($urandom);
            waddr[i*AW +: AW] = AW'($urandom);
            opc[i*OW +: OW]   = OW'($urandom);
            wdata[i*XL +: XL] = $urandom;
            s1[i*XL +: XL]    = $urandom;
            s2[i*XL +: XL]    = $urandom;
        end
    endtask

    task automatic quiet();
        vld = 0; sel = '0; multi = '0; done = '0; wen = '0;
        rand_data();
    endtask

    task automatic issue(input logic [N-1:0] s, input logic [N-1:0] m, input logic [N-1:0] d,
                         input logic [N-1:0] w, input int src, input logic [AW-1:0] a,
                         input logic [XL-1:0] dat);
        rand_data();
        vld = 1; sel = s; multi = m; done = d; wen = w;
        if (src >= 0) begin
            waddr[src*AW +: AW] = a;
            wdata[src*XL +: XL] = dat;
        end
    endtask

    initial begin
        quiet();
        rst = 1;
        repeat (2) step();
        rst = 0;
        step();

        // Back-to-back single-cycle classes.
        issue(4'b0001, '0, '0, 4'b0001, 0, 5'd3, 32'h11); step();
        issue(4'b1000, '0, '0, 4'b1000, 3, 5'd7, 32'h22); step();
        quiet(); step();

        // Multi-cycle lock with sel churn, then owner done with a writeback.
        issue(4'b0100, 4'b0100, '0, '0, -1, '0, '0); step();
        for (int k = 0; k < 4; k++) begin
            issue(4'(1 << (k % 4)), '0, 4'b0011, '0, -1, '0, '0); step();
        end
        issue(4'b0001, '0, 4'b0100, 4'b0100, 2, 5'd9, 32'hDEADBEEF); step();
        quiet(); step(); step();

        // Same-cycle completion never locks.
        issue(4'b0100, 4'b0100, 4'b0100, 4'b0100, 2, 5'd5, 32'h55); step();
        quiet(); step();

        // Invalid selects are dropped.
        issue(4'b0110, '0, '0, 4'b0110, -1, '0, '0); step();
        issue(4'b0000, '0, '0, 4'b1111, -1, '0, '0); step();
        quiet(); step();

        // Timeout, then a late done is ignored.
        issue(4'b0010, 4'b0010, '0, '0, -1, '0, '0); step();
        quiet();
        repeat (10) step();
        done = 4'b0010; step();
        quiet(); step();

        // x0 writes suppressed.
        issue(4'b0001, '0, '0, 4'b0001, 0, 5'd0, 32'hFFFF); step();
        quiet(); step();

        // Reset in the middle of a lock.
        issue(4'b1000, 4'b1000, '0, '0, -1, '0, '0); step();
        quiet(); step();
        rst = 1; step();
        rst = 0; step(); step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rand_data();
            vld = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            if (r == 0) sel = '0;
            else if (r == 1) sel = N'($urandom);
            else sel = N'(1 << $urandom_range(0, N - 1));
            multi = N'($urandom);
            for (int i = 0; i < N; i++) done[i] = ($urandom_range(0, 4) == 0);
            wen = N'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 0;
        quiet();
        repeat (12) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
